// File: rtl/mem_arb_pkg.sv
// Shared command constants, FSM/grant enums and the misalignment helper for mem_arbiter.
// The helper is only referenced when MEM_ARB_MISALIGN_CHECK_EN is defined.
package mem_arb_pkg;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {GNT_IF, GNT_D} grant_e;

  // A data access is misaligned when its mask is not a natural byte/half/word lane
  // pattern or its lowest enabled lane disagrees with the byte offset of the address.
  function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] addr_lo);
    logic       legal;
    logic [1:0] low;
    legal = (mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    low   = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    return !legal || (low != addr_lo);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last,
  output grant_e     grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = GNT_IF;
    if (req == 2'b11) begin
      grant = (last == GNT_IF) ? GNT_D : GNT_IF;
    end else if (req[1]) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word memory between instruction fetch and load/store.
// Optional MEM_ARB_MISALIGN_CHECK_EN adds d_err and suppresses misaligned data accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_cmd,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH/8-1:0] d_mask,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  output logic                    d_err,
`endif
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_mask,
  output logic                    mem_enable,
  output logic                    mem_cmd,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_load_data,
  input  logic                    mem_valid,
  output logic                    busy
);

  localparam int MASK_W = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  grant_e                last_q, last_d, gnt_q, gnt_d, pick_grant;
  logic                  pick_valid, d_misaligned;
  logic                  cmd_q, cmd_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [MASK_W-1:0]     mem_mask_q, mem_mask_d;
  logic                  mem_enable_q, mem_enable_d, mem_cmd_q, mem_cmd_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, rdata_cap;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                  if_ack_q, if_ack_d, d_ack_q, d_ack_d;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic                  d_err_q, d_err_d;
`endif

  rr_pick2 u_pick (
    .req   ({d_req, if_req}),
    .last  (last_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign d_misaligned = misaligned(d_mask, d_addr[1:0]);
`else
  assign d_misaligned = 1'b0;
`endif

  assign rdata_cap = (cmd_q == MEM_CMD_READ && mem_valid && !err_q) ? mem_load_data : '0;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    cmd_d        = cmd_q;
    err_d        = err_q;
    mem_addr_d   = '0;
    mem_mask_d   = '0;
    mem_enable_d = 1'b0;
    mem_cmd_d    = 1'b0;
    mem_wdata_d  = '0;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = '0;
    d_rdata_d    = '0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    d_err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          gnt_d   = pick_grant;
          last_d  = pick_grant;
          if (pick_grant == GNT_IF) begin
            cmd_d      = MEM_CMD_READ;
            err_d      = 1'b0;
            mem_addr_d = if_addr;
            mem_mask_d = '1;
          end else begin
            cmd_d       = d_cmd;
            err_d       = d_misaligned;
            mem_addr_d  = d_addr;
            mem_mask_d  = d_mask;
            mem_wdata_d = d_wdata;
          end
          mem_cmd_d    = cmd_d;
          mem_enable_d = !err_d;
          // A rejected access keeps the whole memory interface quiet.
          if (err_d) begin
            mem_addr_d  = '0;
            mem_mask_d  = '0;
            mem_cmd_d   = 1'b0;
            mem_wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (gnt_q == GNT_IF) begin
          if_ack_d   = 1'b1;
          if_rdata_d = rdata_cap;
        end else begin
          d_ack_d   = 1'b1;
          d_rdata_d = rdata_cap;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
          d_err_d   = err_q;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= GNT_D;
      gnt_q        <= GNT_IF;
      cmd_q        <= MEM_CMD_READ;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_mask_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_cmd_q    <= 1'b0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      d_err_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      cmd_q        <= cmd_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_mask_q   <= mem_mask_d;
      mem_enable_q <= mem_enable_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      d_err_q      <= d_err_d;
`endif
    end
  end

  assign if_ack         = if_ack_q;
  assign if_rdata       = if_rdata_q;
  assign d_ack          = d_ack_q;
  assign d_rdata        = d_rdata_q;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign d_err          = d_err_q;
`endif
  assign mem_addr       = mem_addr_q;
  assign mem_mask       = mem_mask_q;
  assign mem_enable     = mem_enable_q;
  assign mem_cmd        = mem_cmd_q;
  assign mem_write_data = mem_wdata_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a word-memory slave and a
// transaction-level reference model (round-robin rule plus a reference memory array).
module tb_mem_arbiter;

  logic        clk, reset;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_cmd, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_mask, mem_mask;
  logic [31:0] mem_addr, mem_write_data, mem_load_data;
  logic        mem_enable, mem_cmd, mem_valid, busy;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic        d_err;
`endif

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_ack         (if_ack),
    .if_rdata       (if_rdata),
    .d_req          (d_req),
    .d_cmd          (d_cmd),
    .d_addr         (d_addr),
    .d_mask         (d_mask),
    .d_wdata        (d_wdata),
    .d_ack          (d_ack),
    .d_rdata        (d_rdata),
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    .d_err          (d_err),
`endif
    .mem_addr       (mem_addr),
    .mem_mask       (mem_mask),
    .mem_enable     (mem_enable),
    .mem_cmd        (mem_cmd),
    .mem_write_data (mem_write_data),
    .mem_load_data  (mem_load_data),
    .mem_valid      (mem_valid),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic        preload;
  logic [3:0]  legal_masks [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] lowbit(input logic [3:0] m);
    for (int b = 0; b < 4; b++) if (m[b]) return 2'(b);
    return 2'd0;
  endfunction

  // Word memory slave: combinational read, byte-masked write on the clock edge.
  assign mem_load_data = mem[mem_addr[7:2]];
  assign mem_valid     = mem_enable;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (mem_enable && mem_cmd) begin
      mem[mem_addr[7:2]] <= lane_merge(mem[mem_addr[7:2]], mem_write_data, mem_mask);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_if_ack"},   32'(if_ack),     32'd0);
    chk({tag, "_d_ack"},    32'(d_ack),      32'd0);
    chk({tag, "_if_rdata"}, if_rdata,        32'd0);
    chk({tag, "_d_rdata"},  d_rdata,         32'd0);
    chk({tag, "_mem_en"},   32'(mem_enable), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr,        32'd0);
    chk({tag, "_mem_mask"}, 32'(mem_mask),   32'd0);
    chk({tag, "_mem_cmd"},  32'(mem_cmd),    32'd0);
    chk({tag, "_mem_wd"},   mem_write_data,  32'd0);
    chk({tag, "_busy"},     32'(busy),       32'd0);
  endtask

  task automatic do_reset();
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        pend_if, pend_d, win_d, last_w, exp_cmd;
    logic [31:0] exp_addr, exp_rd;
    logic [5:0]  widx;
    logic [3:0]  m;

    reset = 1'b1; preload = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_cmd = 1'b0; d_addr = '0; d_mask = '0; d_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom();
    ref_mem[4] = 32'hDEADBEEF;
    ref_mem[8] = 32'hAABBCCDD;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    tick();
    check_quiet("reset");
    reset = 1'b0;

    // Lone fetch of word 4
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    chk("fetch_en",   32'(mem_enable), 32'd1);
    chk("fetch_cmd",  32'(mem_cmd),    32'd0);
    chk("fetch_mask", 32'(mem_mask),   32'hF);
    chk("fetch_addr", mem_addr,        32'h10);
    chk("fetch_busy", 32'(busy),       32'd1);
    tick();
    chk("fetch_ack",   32'(if_ack), 32'd1);
    chk("fetch_rdata", if_rdata,    32'hDEADBEEF);
    chk("fetch_dack",  32'(d_ack),  32'd0);
    if_req = 1'b0;
    tick();
    chk("fetch_ack_end",   32'(if_ack), 32'd0);
    chk("fetch_rdata_end", if_rdata,    32'd0);
    chk("fetch_idle",      32'(busy),   32'd0);

    // Masked halfword store into word 8, then read back
    d_req = 1'b1; d_cmd = 1'b1; d_addr = 32'h20; d_mask = 4'b0011; d_wdata = 32'h0000_1234;
    tick();
    chk("st_en",   32'(mem_enable), 32'd1);
    chk("st_cmd",  32'(mem_cmd),    32'd1);
    chk("st_mask", 32'(mem_mask),   32'h3);
    chk("st_wd",   mem_write_data,  32'h0000_1234);
    tick();
    chk("st_ack",    32'(d_ack),  32'd1);
    chk("st_rdata",  d_rdata,     32'd0);
    chk("st_if_ack", 32'(if_ack), 32'd0);
    d_req = 1'b0;
    ref_mem[8] = 32'hAABB1234;
    tick();
    d_req = 1'b1; d_cmd = 1'b0; d_mask = 4'hF;
    tick();
    tick();
    chk("ld_ack",   32'(d_ack), 32'd1);
    chk("ld_rdata", d_rdata,    32'hAABB1234);
    d_req = 1'b0;
    tick();

    // Tie straight after reset: fetch first, data follows
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_cmd = 1'b0; d_addr = 32'h20; d_mask = 4'hF;
    tick();
    chk("tie_c1_addr", mem_addr, 32'h10);
    tick();
    chk("tie_c2_if_ack", 32'(if_ack), 32'd1);
    chk("tie_c2_d_ack",  32'(d_ack),  32'd0);
    chk("tie_c2_rdata",  if_rdata,    32'hDEADBEEF);
    if_req = 1'b0;
    tick();
    chk("tie_c3_if_ack", 32'(if_ack), 32'd0);
    chk("tie_c3_d_ack",  32'(d_ack),  32'd0);
    tick();
    chk("tie_c4_en",   32'(mem_enable), 32'd1);
    chk("tie_c4_addr", mem_addr,        32'h20);
    tick();
    chk("tie_c5_d_ack", 32'(d_ack), 32'd1);
    chk("tie_c5_rdata", d_rdata,    32'hAABB1234);
    d_req = 1'b0;
    tick();

    // Continuous contention: grants alternate, one ack every third cycle
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_cmd = 1'b0; d_addr = 32'h20; d_mask = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("cont_if_ack_c%0d", c), 32'(if_ack), 32'((c % 3 == 2) && ((c / 3) % 2 == 0)));
      chk($sformatf("cont_d_ack_c%0d", c),  32'(d_ack),  32'((c % 3 == 2) && ((c / 3) % 2 == 1)));
      if (c == 12) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    tick();
    chk("cont_end_busy", 32'(busy), 32'd0);

    // Reset while the access cycle is in progress
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    chk("rstmid_en", 32'(mem_enable), 32'd1);
    reset = 1'b1;
    tick();
    check_quiet("rstmid");
    reset = 1'b0;
    if_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rstmid_no_ack", 32'(if_ack), 32'd0);
      chk("rstmid_idle",   32'(busy),   32'd0);
    end

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    // Misaligned halfword store is rejected without touching memory
    d_req = 1'b1; d_cmd = 1'b1; d_addr = 32'h21; d_mask = 4'b0011; d_wdata = 32'h0000_FFFF;
    tick();
    chk("mis_en", 32'(mem_enable), 32'd0);
    tick();
    chk("mis_ack",   32'(d_ack), 32'd1);
    chk("mis_err",   32'(d_err), 32'd1);
    chk("mis_rdata", d_rdata,    32'd0);
    d_req = 1'b0;
    tick();
    chk("mis_err_end", 32'(d_err), 32'd0);
    chk("mis_mem",     mem[8],     32'hAABB1234);
`endif

    // Randomized traffic against the transaction-level model
    preload = 1'b1;
    tick();
    preload = 1'b0;
    do_reset();
    last_w = 1'b1;
    for (int r = 0; r < 60; r++) begin
      pend_if = 1'($urandom_range(0, 1));
      pend_d  = 1'($urandom_range(0, 1));
      if (!pend_if && !pend_d) pend_if = 1'b1;
      if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      m       = legal_masks[$urandom_range(0, 6)];
      d_mask  = m;
      d_addr  = {24'h0, 6'($urandom_range(0, 63)), lowbit(m)};
      d_cmd   = 1'($urandom_range(0, 1));
      d_wdata = $urandom();
      if_req  = pend_if;
      d_req   = pend_d;
      while (pend_if || pend_d) begin
        win_d    = (pend_if && pend_d) ? !last_w : pend_d;
        exp_addr = win_d ? d_addr : if_addr;
        exp_cmd  = win_d ? d_cmd : 1'b0;
        widx     = exp_addr[7:2];
        exp_rd   = exp_cmd ? 32'd0 : ref_mem[widx];
        tick();
        chk("rnd_en",   32'(mem_enable), 32'd1);
        chk("rnd_addr", mem_addr,        exp_addr);
        chk("rnd_cmd",  32'(mem_cmd),    32'(exp_cmd));
        tick();
        chk("rnd_if_ack", 32'(if_ack), 32'(!win_d));
        chk("rnd_d_ack",  32'(d_ack),  32'(win_d));
        chk("rnd_rdata",  win_d ? d_rdata : if_rdata, exp_rd);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        chk("rnd_d_err", 32'(d_err), 32'd0);
`endif
        if (win_d && exp_cmd) ref_mem[widx] = lane_merge(ref_mem[widx], d_wdata, d_mask);
        if (win_d) begin
          d_req  = 1'b0;
          pend_d = 1'b0;
        end else begin
          if_req  = 1'b0;
          pend_if = 1'b0;
        end
        last_w = win_d;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-port simulated word memory of the RV32I core.
- Shares the memory between the instruction-fetch port (read-only) and the load/store data port (read/write with byte mask).
- Runs each granted request as a fixed IDLE -> ACCESS -> RESP sequence and drives the memory's addr/mask/enable/cmd/write_data interface.
- Arbitration is round-robin; one transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data width; mask width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_WIDTH  fetch data; valid only while if_ack is high, 0 otherwise.
- d_req  in  1  data request; held high until d_ack.
- d_cmd  in  1  0 = read, 1 = write.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_mask  in  4  byte-lane write mask.
- d_wdata  in  DATA_WIDTH  write data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_WIDTH  load data while d_ack is high; 0 for writes and when not acking.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_mask  out  4  to memory mask.
- mem_enable  out  1  to memory enable.
- mem_cmd  out  1  to memory cmd.
- mem_write_data  out  DATA_WIDTH  to memory write_data.
- mem_load_data  in  DATA_WIDTH  from memory load_data (combinational on the memory side).
- mem_valid  in  1  from memory valid.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: state = IDLE and last_grant = DATA, so fetch wins the first tie. All outputs are 0: acks, rdata, mem_*, busy.
- Reset mid-operation:
  - Sync reset; the ACCESS cycle in progress is not aborted.
  - The next state is IDLE, the pending ack is dropped and the transaction is lost.
  - Requesters re-request.
- IDLE:
  - Sample if_req and d_req.
  - If exactly one is high, grant it. If both are high, grant the one that is not last_grant.
  - Latch the winner's addr, mask, cmd and wdata into internal registers and update last_grant.
  - Fetch always latches mask = 4'hF and cmd = read.
  - Move to ACCESS. With no request, stay in IDLE.
- ACCESS:
  - Exactly one cycle with mem_enable = 1 and mem_addr, mem_mask, mem_cmd, mem_write_data taken from the latched registers.
  - For a read, capture rdata_q = mem_valid ? mem_load_data : 0.
  - For a write, rdata_q = 0.
  - Move to RESP.
- RESP:
  - mem_enable = 0 and mem_* data outputs return to 0.
  - Pulse the winner's ack for one cycle, driving rdata_q on the winner's rdata.
  - Move to IDLE.
- Latency: request sampled in cycle N, memory access in N+1, ack in N+2. Throughput is one transaction per 3 cycles.
- Handshake:
  - A requester keeps req and its fields stable until ack.
  - req still high in the cycle after ack is treated as a new request.
  - Changes to the granted requester's fields after the IDLE sample are ignored.
- Fairness: when both requesters are held high continuously, grants alternate strictly and neither waits more than one transaction.
- The non-granted ack stays 0. Both acks are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_MISALIGN_CHECK_EN.
- When defined:
  - Adds output d_err (1 bit), which pulses together with d_ack.
  - A data request is misaligned when d_mask is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111, or when the index of its lowest set bit does not equal d_addr[1:0].
  - For a misaligned request, ACCESS keeps mem_enable = 0, the memory is untouched, d_rdata = 0 and d_err = 1. Latency is unchanged.
- When not defined: there is no d_err port, no check is made, and every request reaches the memory.

Decomposition:
- Package mem_arb_pkg holds:
  - MEM_CMD_READ / MEM_CMD_WRITE constants.
  - State enum {IDLE, ACCESS, RESP}.
  - Grant enum {GNT_IF, GNT_D}.
- One natural sub-module, rr_pick2: a two-way round-robin picker with inputs req[1:0] and last, and outputs grant and valid.

Test Plan:
- Lone fetch: memory word 4 = 0xDEADBEEF, if_req with if_addr = 0x10 in cycle 0 -> cycle 1 has mem_enable = 1, mem_cmd = 0, mem_mask = F; cycle 2 has if_ack = 1 and if_rdata = 0xDEADBEEF.
- Masked store: word 8 = 0xAABBCCDD, d_cmd = 1, d_addr = 0x20, d_mask = 0011, d_wdata = 0x00001234 -> d_ack in cycle 2 with d_rdata = 0; a subsequent load returns 0xAABB1234.
- Tie after reset: both req in cycle 0 -> if_ack in cycle 2; data is sampled in cycle 3 and d_ack arrives in cycle 5.
- Continuous contention: both req held for 12 cycles -> acks in the order IF, D, IF, D at cycles 2, 5, 8, 11.
- Reset during ACCESS -> the next cycle is IDLE with busy = 0; no ack ever appears for that request; all outputs are 0.
- MEM_ARB_MISALIGN_CHECK_EN: d_mask = 0011 with d_addr = 0x21 -> mem_enable stays 0, d_ack and d_err both high in cycle 2, the memory word is unchanged.
